// File: rtl/upstream_data_n_ack_pkg.sv
// Shared definitions for the Dini host stream data/ack paths (upstream and
// downstream): transfer state encodings, tohost/fromhost ctrl bit indices and
// descriptor field positions, plus a helper that builds a data-word ctrl byte.
package upstream_data_n_ack_pkg;

  localparam int CNT_W_DEF = 24;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR1      = 3'd1,
    S_DATA      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ACK       = 3'd4
  } xfer_state_e;

  // Stream ctrl byte bit indices
  localparam int CTRL_HDR0     = 0;
  localparam int CTRL_LAST     = 1;
  localparam int CTRL_LO_VALID = 2;
  localparam int CTRL_HI_VALID = 3;
  localparam int CTRL_DATA     = 4;
  localparam int CTRL_HDR1     = 5;

  // Descriptor field positions inside the 64-bit header words
  localparam int DESC_TAG_LSB = 4;   // hdr0: tag in [7:4]
  localparam int DESC_LEN_LSB = 0;   // hdr1: length in [23:0]
  localparam int DESC_LEN_W   = 24;

  function automatic logic [7:0] hdr_ctrl(input logic second);
    logic [7:0] c;
    c = '0;
    if (second) c[CTRL_HDR1] = 1'b1;
    else        c[CTRL_HDR0] = 1'b1;
    return c;
  endfunction

  function automatic logic [7:0] data_ctrl(input logic hi_valid, input logic last);
    logic [7:0] c;
    c = '0;
    c[CTRL_DATA]     = 1'b1;
    c[CTRL_LO_VALID] = 1'b1;
    c[CTRL_HI_VALID] = hi_valid;
    c[CTRL_LAST]     = last;
    return c;
  endfunction

endpackage

// File: rtl/upstream_data_n_ack_tohost_out_reg.sv
// One-entry registered output stage for the tohost stream.
// A new payload is taken whenever the slot is free (empty, or the current word
// is being accepted this cycle); otherwise payload and valid are held.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load_valid     producer offers load_payload this cycle
//   load_payload   {ctrl, data} word to register
//   slot_free      producer may load this cycle
//   accept         consumer takes the registered word when valid
//   payload, valid registered outputs (no combinational path from accept)
module upstream_data_n_ack_tohost_out_reg #(
  parameter int PAYLOAD_W = 72
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  input  logic [PAYLOAD_W-1:0] load_payload,
  output logic                 slot_free,
  input  logic                 accept,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 valid
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  always_comb begin
    slot_free = ~valid_q | accept;
    valid_d   = valid_q;
    payload_d = payload_q;
    if (slot_free) begin
      // An accepted word with nothing new behind it empties the slot.
      valid_d = load_valid;
      if (load_valid) payload_d = load_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign payload = payload_q;
  assign valid   = valid_q;

endmodule

// File: rtl/upstream_data_n_ack.sv
// Upstream (to-host) data/ack path. On a DMA-controller request it emits a
// two-word ack descriptor (hdr0 = tag, hdr1 = length) on the tohost stream,
// enables the bus interface and forwards aligner read data two dwords per
// word, then waits for the bus interface to finish and acknowledges the
// fragment to the DMA controller.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   upstream_req/_tag/_length  fragment request (level, held until accept)
//   upstream_req_accept        1-cycle pulse after the request is latched
//   upstream_ack/_tag/_length  end-of-fragment ack, held until upstream_ack_ack
//   upstream_ack_ack           DMA controller consumes the ack
//   busif_start / busif_done   bus interface read enable / finished (level)
//   aligner_data/_valid/_ready read data from the aligner, dword0 in [31:0]
//   tohost_data/_ctrl/_valid   registered stream word, held until accept
//   tohost_accept              FIFO takes the word when valid & accept
module upstream_data_n_ack
  import upstream_data_n_ack_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upstream_req,
  input  logic [TAG_W-1:0] upstream_req_tag,
  input  logic [CNT_W-1:0] upstream_req_length,
  output logic             upstream_req_accept,
  output logic             upstream_ack,
  output logic [TAG_W-1:0] upstream_ack_tag,
  output logic [15:0]      upstream_ack_length,
  input  logic             upstream_ack_ack,
  output logic             busif_start,
  input  logic             busif_done,
  input  logic [63:0]      aligner_data,
  input  logic             aligner_valid,
  output logic             aligner_ready,
  output logic [63:0]      tohost_data,
  output logic [7:0]       tohost_ctrl,
  output logic             tohost_valid,
  input  logic             tohost_accept
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  xfer_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ack_q, ack_d;
  logic             busif_start_q, busif_start_d;
  logic             req_accept_q, req_accept_d;

  logic             slot_free;
  logic             load_valid;
  logic [63:0]      load_data;
  logic [7:0]       load_ctrl;
  logic             count_ge2;

  assign count_ge2 = (count_q >= CNT_TWO);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    len_d         = len_q;
    tag_d         = tag_q;
    ack_d         = ack_q;
    busif_start_d = busif_start_q;
    req_accept_d  = 1'b0;
    load_valid    = 1'b0;
    load_data     = '0;
    load_ctrl     = '0;
    aligner_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (upstream_req && slot_free) begin
          tag_d        = upstream_req_tag;
          len_d        = upstream_req_length;
          count_d      = upstream_req_length;
          req_accept_d = 1'b1;
          load_valid   = 1'b1;
          load_data[DESC_TAG_LSB +: TAG_W] = upstream_req_tag;
          load_ctrl    = hdr_ctrl(1'b0);
          state_d      = S_HDR1;
        end
      end

      S_HDR1: begin
        if (slot_free) begin
          load_valid = 1'b1;
          load_data[DESC_LEN_LSB +: CNT_W] = len_q;
          load_ctrl  = hdr_ctrl(1'b1);
          if (len_q == '0) begin
            // Nothing to read: skip the bus interface and ack right away.
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            busif_start_d = 1'b1;
            state_d       = S_DATA;
          end
        end
      end

      S_DATA: begin
        aligner_ready = slot_free;
        if (aligner_valid && slot_free) begin
          load_valid = 1'b1;
          load_data  = aligner_data;
          // hi dword valid while at least two dwords remain; last when <= 2.
          load_ctrl  = data_ctrl(count_ge2, count_q <= CNT_TWO);
          count_d    = count_q - (count_ge2 ? CNT_TWO : CNT_ONE);
          if (count_d == '0) state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (busif_done) begin
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        if (upstream_ack_ack) begin
          ack_d         = 1'b0;
          busif_start_d = 1'b0;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      len_q         <= '0;
      tag_q         <= '0;
      ack_q         <= 1'b0;
      busif_start_q <= 1'b0;
      req_accept_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      len_q         <= len_d;
      tag_q         <= tag_d;
      ack_q         <= ack_d;
      busif_start_q <= busif_start_d;
      req_accept_q  <= req_accept_d;
    end
  end

  upstream_data_n_ack_tohost_out_reg #(
    .PAYLOAD_W (72)
  ) u_out_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_payload ({load_ctrl, load_data}),
    .slot_free    (slot_free),
    .accept       (tohost_accept),
    .payload      ({tohost_ctrl, tohost_data}),
    .valid        (tohost_valid)
  );

  assign upstream_req_accept = req_accept_q;
  assign upstream_ack        = ack_q;
  assign upstream_ack_tag    = tag_q;
  assign upstream_ack_length = len_q[15:0];
  assign busif_start         = busif_start_q;

`ifdef RW_SIMU
  string state_name;
  always_comb begin
    state_name = "";
    case (state_q)
      S_IDLE:      state_name = "S_IDLE";
      S_HDR1:      state_name = "S_HDR1";
      S_DATA:      state_name = "S_DATA";
      S_WAIT_DONE: state_name = "S_WAIT_DONE";
      S_ACK:       state_name = "S_ACK";
      default:     state_name = "S_UNKNOWN";
    endcase
  end
`endif

endmodule
